// File: rtl/div_line.sv
// div_line: pipelined unsigned restoring divider, one quotient bit per stage,
// MSB first. Accepts one dividend/divisor pair per clock (qualified by rdy) and
// returns quotient/remainder DIVLEN_1 cycles later, flagged by valid.
// Optional feature: define DIV_LINE_DBZ_EN to add the div_zero output, a
// divide-by-zero flag carried alongside the valid chain.
// A zero divisor is not special-cased: it naturally yields an all-ones quotient
// and a remainder equal to the low DIVLEN_2 dividend bits.
module div_line #(
    parameter int DIVLEN_1 = 8,
    parameter int DIVLEN_2 = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [DIVLEN_1-1:0] dividend,
    input  logic [DIVLEN_2-1:0] divisor,
    output logic [DIVLEN_1-1:0] quotient,
    output logic [DIVLEN_2-1:0] remainder,
    output logic                valid
`ifdef DIV_LINE_DBZ_EN
    ,
    output logic                div_zero
`endif
);

    // One restoring step: shift in the next dividend bit, subtract the divisor
    // when it fits. Returns {quotient_bit, new_partial_remainder}.
    // While the incoming remainder is below the divisor, the shifted value is
    // below twice the divisor, so the difference always fits in DIVLEN_2 bits
    // and modular DIVLEN_2-bit subtraction is exact.
    function automatic logic [DIVLEN_2:0] div_step(
        input logic [DIVLEN_2-1:0] rem,
        input logic                nbit,
        input logic [DIVLEN_2-1:0] dsr
    );
        logic [DIVLEN_2:0]   sh;
        logic                ge;
        logic [DIVLEN_2-1:0] nrem;
        sh   = {rem, nbit};
        ge   = (sh >= {1'b0, dsr});
        nrem = sh[DIVLEN_2-1:0] - (ge ? dsr : '0);
        return {ge, nrem};
    endfunction

    for (genvar k = 0; k < DIVLEN_1; k++) begin : g_stage
        // Dividend bits still to be consumed when entering this stage.
        localparam int IW = DIVLEN_1 - k;

        logic [IW-1:0]       s_dvd;
        logic [DIVLEN_2-1:0] s_dsr;
        logic [DIVLEN_2-1:0] s_rem;
        logic                s_vld;
        logic [DIVLEN_2:0]   step;
        logic [k:0]          nquo;

        // Stage registers: quotient grows by one bit per stage.
        logic [k:0]          quo_p;
        logic [DIVLEN_2-1:0] rem_p;
        logic                vld_p;
`ifdef DIV_LINE_DBZ_EN
        logic                s_dbz;
        logic                dbz_p;
`endif

        if (k == 0) begin : g_head
            assign s_dvd = dividend;
            assign s_dsr = divisor;
            assign s_rem = '0;
            assign s_vld = rdy;
            assign nquo  = step[DIVLEN_2];
`ifdef DIV_LINE_DBZ_EN
            assign s_dbz = rdy && (divisor == '0);
`endif
        end else begin : g_body
            assign s_dvd = g_stage[k-1].g_fwd.dvd_p;
            assign s_dsr = g_stage[k-1].g_fwd.dsr_p;
            assign s_rem = g_stage[k-1].rem_p;
            assign s_vld = g_stage[k-1].vld_p;
            assign nquo  = {g_stage[k-1].quo_p, step[DIVLEN_2]};
`ifdef DIV_LINE_DBZ_EN
            assign s_dbz = g_stage[k-1].dbz_p;
`endif
        end

        assign step = div_step(s_rem, s_dvd[IW-1], s_dsr);

        // Stage k: valid always advances; result data loads only for a valid slot.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= 1'b0;
                quo_p <= '0;
                rem_p <= '0;
            end else begin
                vld_p <= s_vld;
                if (s_vld) begin
                    quo_p <= nquo;
                    rem_p <= step[DIVLEN_2-1:0];
                end
            end
        end

`ifdef DIV_LINE_DBZ_EN
        // Divide-by-zero flag rides the valid chain, so it is 0 in bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dbz_p <= 1'b0;
            end else begin
                dbz_p <= s_dbz;
            end
        end
`endif

        // Operands forwarded to the next stage; the last stage needs none.
        if (k < DIVLEN_1 - 1) begin : g_fwd
            logic [IW-2:0]       dvd_p;
            logic [DIVLEN_2-1:0] dsr_p;

            // Stage k operand carry: unconsumed dividend bits and the divisor.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dvd_p <= '0;
                    dsr_p <= '0;
                end else if (s_vld) begin
                    dvd_p <= s_dvd[IW-2:0];
                    dsr_p <= s_dsr;
                end
            end
        end
    end

    assign quotient  = g_stage[DIVLEN_1-1].quo_p;
    assign remainder = g_stage[DIVLEN_1-1].rem_p;
    assign valid     = g_stage[DIVLEN_1-1].vld_p;
`ifdef DIV_LINE_DBZ_EN
    assign div_zero  = g_stage[DIVLEN_1-1].dbz_p;
`endif

endmodule

// File: tb/tb_div_line.sv
// tb_div_line: scoreboard bench for div_line. Expected results are queued when
// a pair is driven and popped when valid appears, along with the cycle on which
// the result must arrive.
module tb_div_line;
    localparam int W1  = 8;
    localparam int W2  = 8;
    localparam int LAT = W1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic [W1-1:0] dividend;
    logic [W2-1:0] divisor;
    logic [W1-1:0] quotient;
    logic [W2-1:0] remainder;
    logic          valid;
`ifdef DIV_LINE_DBZ_EN
    logic          div_zero;
`endif

    typedef struct {
        logic [W1-1:0] q;
        logic [W2-1:0] r;
        logic          dz;
        int            t;
    } exp_t;

    exp_t sb[$];
    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    div_line #(.DIVLEN_1(W1), .DIVLEN_2(W2)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .valid(valid)
`ifdef DIV_LINE_DBZ_EN
        ,
        .div_zero(div_zero)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one pair at the falling edge and queue its expected result.
    task automatic send(input logic [W1-1:0] a, input logic [W2-1:0] b,
                        input logic [W1-1:0] eq, input logic [W2-1:0] er);
        @(negedge clk);
        rdy      = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back('{q: eq, r: er, dz: (b == '0), t: cyc});
    endtask

    // Drive a bubble with junk operands.
    task automatic bubble();
        @(negedge clk);
        rdy      = 1'b0;
        dividend = W1'($urandom);
        divisor  = W2'($urandom);
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; rdy = 1'b1; dividend = 8'd99; divisor = 8'd3;
        #40;
        total++; if (quotient !== '0) $display("FAIL reset_q: got %0d, required 0", quotient); else passed++;
        total++; if (remainder !== '0) $display("FAIL reset_r: got %0d, required 0", remainder); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid); else passed++;
`ifdef DIV_LINE_DBZ_EN
        total++; if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b, required 0", div_zero); else passed++;
`endif
        #10;
        rst = 1'b0; rdy = 1'b0;
        pulses = 0;
        for (int w = 0; w < LAT + 4; w++) begin
            @(negedge clk);
            if (valid !== 1'b0) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL reset_idle: %0d valid pulses, required 0", pulses); else passed++;
    endtask

    task automatic test_basic();
        int got = 0;
        sb.delete();
        send(8'd125, 8'd5, 8'd25, 8'd0);
        send(8'd160, 8'd10, 8'd16, 8'd0);
        send(8'd100, 8'd7, 8'd14, 8'd2);
        bubble();
        for (int w = 0; w < LAT + 20 && got < 3; w++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                exp_t e;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL basic_extra: q=%0d r=%0d, required no result", quotient, remainder);
                end else begin
                    e = sb.pop_front(); got++;
                    if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL basic_data: q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r); else passed++;
                    total++; if (cyc !== e.t + LAT) $display("FAIL basic_latency: cycle %0d, required %0d", cyc, e.t + LAT); else passed++;
                end
            end
        end
        total++; if (got !== 3) $display("FAIL basic_count: %0d results, required 3", got); else passed++;
    endtask

    task automatic test_edges();
        int got = 0;
        sb.delete();
        send(8'd255, 8'd1, 8'd255, 8'd0);
        send(8'd255, 8'd255, 8'd1, 8'd0);
        send(8'd0, 8'd9, 8'd0, 8'd0);
        send(8'd3, 8'd200, 8'd0, 8'd3);
        bubble();
        for (int w = 0; w < LAT + 20 && got < 4; w++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                exp_t e;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL edges_extra: q=%0d r=%0d, required no result", quotient, remainder);
                end else begin
                    e = sb.pop_front(); got++;
                    if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL edges_data: q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r); else passed++;
                    total++; if (cyc !== e.t + LAT) $display("FAIL edges_latency: cycle %0d, required %0d", cyc, e.t + LAT); else passed++;
                end
            end
        end
        total++; if (got !== 4) $display("FAIL edges_count: %0d results, required 4", got); else passed++;
    endtask

    task automatic test_div_zero();
        int got = 0;
        sb.delete();
        send(8'd9, 8'd3, 8'd3, 8'd0);
        send(8'd37, 8'd0, 8'd255, 8'd37);
        send(8'd20, 8'd4, 8'd5, 8'd0);
        bubble();
        for (int w = 0; w < LAT + 20 && got < 3; w++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                exp_t e;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL dbz_extra: q=%0d r=%0d, required no result", quotient, remainder);
                end else begin
                    e = sb.pop_front(); got++;
                    if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL dbz_data: q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r); else passed++;
                    total++; if (cyc !== e.t + LAT) $display("FAIL dbz_latency: cycle %0d, required %0d", cyc, e.t + LAT); else passed++;
`ifdef DIV_LINE_DBZ_EN
                    total++; if (div_zero !== e.dz) $display("FAIL dbz_flag: got %b, required %b", div_zero, e.dz); else passed++;
`endif
                end
            end
        end
        total++; if (got !== 3) $display("FAIL dbz_count: %0d results, required 3", got); else passed++;
    endtask

    task automatic test_sweep();
        int dl[7] = '{7, 1, 15, 3, 11, 4, 9};
        int n = 7 * 256;
        sb.delete();
        fork
            begin
                for (int d = 0; d < 7; d++) begin
                    for (int a = 0; a < 256; a++) begin
                        send(W1'(a), W2'(dl[d]), W1'(a / dl[d]), W2'(a % dl[d]));
                    end
                end
                bubble();
            end
            begin
                int got = 0;
                for (int w = 0; w < n + LAT + 20 && got < n; w++) begin
                    @(negedge clk);
                    if (valid === 1'b1) begin
                        exp_t e;
                        total++;
                        if (sb.size() == 0) begin
                            $display("FAIL sweep_extra: q=%0d r=%0d, required no result", quotient, remainder);
                        end else begin
                            e = sb.pop_front(); got++;
                            if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL sweep_data: q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r); else passed++;
                            total++; if (cyc !== e.t + LAT) $display("FAIL sweep_latency: cycle %0d, required %0d", cyc, e.t + LAT); else passed++;
`ifdef DIV_LINE_DBZ_EN
                            total++; if (div_zero !== 1'b0) $display("FAIL sweep_flag: got %b, required 0", div_zero); else passed++;
`endif
                        end
                    end
                end
                total++; if (got !== n) $display("FAIL sweep_count: %0d results, required %0d", got, n); else passed++;
            end
        join
    endtask

    task automatic test_bubble();
        int w = 0;
        int t0;
        sb.delete();
        send(8'd50, 8'd6, 8'd8, 8'd2);
        bubble();
        send(8'd90, 8'd9, 8'd10, 8'd0);
        bubble();
        t0 = sb[0].t;
        while (valid !== 1'b1 && w < LAT + 10) begin
            @(negedge clk);
            w++;
        end
        total++; if (valid !== 1'b1 || quotient !== 8'd8 || remainder !== 8'd2) $display("FAIL bubble_first: v=%b q=%0d r=%0d, required v=1 q=8 r=2", valid, quotient, remainder); else passed++;
        total++; if (cyc !== t0 + LAT) $display("FAIL bubble_latency: cycle %0d, required %0d", cyc, t0 + LAT); else passed++;
        @(negedge clk);
        total++; if (valid !== 1'b0 || quotient !== 8'd8 || remainder !== 8'd2) $display("FAIL bubble_hold: v=%b q=%0d r=%0d, required v=0 q=8 r=2", valid, quotient, remainder); else passed++;
        @(negedge clk);
        total++; if (valid !== 1'b1 || quotient !== 8'd10 || remainder !== 8'd0) $display("FAIL bubble_second: v=%b q=%0d r=%0d, required v=1 q=10 r=0", valid, quotient, remainder); else passed++;
        @(negedge clk);
        total++; if (valid !== 1'b0 || quotient !== 8'd10 || remainder !== 8'd0) $display("FAIL bubble_hold2: v=%b q=%0d r=%0d, required v=0 q=10 r=0", valid, quotient, remainder); else passed++;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int pulses = 0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy      = 1'b1;
            dividend = W1'(40 + i * 10);
            divisor  = W2'(3 + i);
        end
        @(negedge clk);
        rst = 1'b1; dividend = 8'd77; divisor = 8'd7;
        #1;
        total++; if ({valid, quotient, remainder} !== '0) $display("FAIL midrst_clear: v=%b q=%0d r=%0d, required all 0", valid, quotient, remainder); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; rdy = 1'b0;
        send(8'd200, 8'd8, 8'd25, 8'd0);
        bubble();
        for (int w = 0; w < LAT + 20 && got < 1; w++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                exp_t e;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL midrst_extra: q=%0d r=%0d, required no result", quotient, remainder);
                end else begin
                    e = sb.pop_front(); got++;
                    if ({quotient, remainder} !== {e.q, e.r}) $display("FAIL midrst_data: q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r); else passed++;
                    total++; if (cyc !== e.t + LAT) $display("FAIL midrst_latency: cycle %0d, required %0d", cyc, e.t + LAT); else passed++;
                end
            end
        end
        total++; if (got !== 1) $display("FAIL midrst_count: %0d results, required 1", got); else passed++;
        for (int w = 0; w < LAT + 2; w++) begin
            @(negedge clk);
            if (valid !== 1'b0) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL midrst_trailing: %0d valid pulses, required 0", pulses); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_sweep();
        test_bubble();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
